// File: rtl/square_motion_engine.sv
// square_motion_engine
//   Moves four bouncing squares once per video frame. A rising edge on vsync
//   starts an update that steps objects 0..3 in consecutive cycles in private
//   working registers, then commits all positions to the outputs in a single
//   cycle so the renderer never sees a half-updated frame.
//
// Ports
//   clk        pixel clock
//   reset      asynchronous active-high reset
//   vsync      frame sync, synchronous to clk
//   enable     motion enable; low ignores frame ticks (positions freeze)
//   x_pos      4 x 10-bit left-edge X, object i in [10i+9:10i]
//   y_pos      4 x 10-bit top-edge Y, same packing
//   frame_done one-cycle pulse when new positions are committed
//   busy       high while an update (UPDATE or COMMIT) is in progress
//   overrun    one-cycle pulse when a frame tick arrives while busy
//   frame_cnt  committed-frame counter, wraps 255 -> 0
module square_motion_engine #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SIZE     = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        enable,
    output logic [39:0] x_pos,
    output logic [39:0] y_pos,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  frame_cnt
);

    localparam logic [10:0] MAX_X = 11'(H_ACTIVE - SIZE);
    localparam logic [10:0] MAX_Y = 11'(V_ACTIVE - SIZE);

    // Packed {obj3, obj2, obj1, obj0}
    localparam logic [3:0][9:0] RST_X  = {10'd40,  10'd100, 10'd120, 10'd0};
    localparam logic [3:0][9:0] RST_Y  = {10'd200, 10'd400, 10'd300, 10'd300};
    localparam logic [3:0]      RST_DX = 4'b1110;
    localparam logic [3:0]      RST_DY = 4'b1101;

    typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

    state_t          state;
    logic            vsync_q;
    logic [1:0]      idx;
    logic [3:0][9:0] wx;
    logic [3:0][9:0] wy;
    logic [3:0]      dx;
    logic [3:0]      dy;

    logic            tick;
    logic [9:0]      step_x;
    logic [9:0]      step_y;
    logic [10:0]     nx;    // {new_dir, new_pos}
    logic [10:0]     ny;

    // One axis of one object. The sum is formed in 11 bits so a step near
    // the top of the 10-bit range cannot wrap before the clamp comparison.
    function automatic logic [10:0] axis_step(input logic [9:0]  pos,
                                              input logic [9:0]  step,
                                              input logic [10:0] max,
                                              input logic        dir);
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, step};
        if (dir) begin
            if (sum >= max) axis_step = {1'b0, max[9:0]};
            else            axis_step = {1'b1, sum[9:0]};
        end else begin
            if (pos <= step) axis_step = {1'b1, 10'd0};
            else             axis_step = {1'b0, pos - step};
        end
    endfunction

    assign tick = vsync && !vsync_q;

    always_comb begin
        step_x = 10'd7 + {8'd0, idx};
        step_y = 10'd6 + {8'd0, idx};
        nx     = axis_step(wx[idx], step_x, MAX_X, dx[idx]);
        ny     = axis_step(wy[idx], step_y, MAX_Y, dy[idx]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            idx        <= '0;
            wx         <= RST_X;
            wy         <= RST_Y;
            dx         <= RST_DX;
            dy         <= RST_DY;
            x_pos      <= RST_X;
            y_pos      <= RST_Y;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vsync_q    <= vsync;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        state <= UPDATE;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end
                UPDATE: begin
                    if (tick) overrun <= 1'b1;
                    wx[idx] <= nx[9:0];
                    dx[idx] <= nx[10];
                    wy[idx] <= ny[9:0];
                    dy[idx] <= ny[10];
                    idx     <= idx + 2'd1;
                    if (idx == 2'd3) state <= COMMIT;
                end
                COMMIT: begin
                    if (tick) overrun <= 1'b1;
                    x_pos      <= wx;
                    y_pos      <= wy;
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_motion_engine.sv
// tb_square_motion_engine
//   Directed, table-driven check of square_motion_engine: per-frame vectors
//   with hand-computed positions, plus hand-written sequences for the
//   obj1 X bounce, overrun, mid-update reset and frame counter wrap.
module tb_square_motion_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        enable;
    logic [39:0] x_pos;
    logic [39:0] y_pos;
    logic        frame_done;
    logic        busy;
    logic        overrun;
    logic [7:0]  frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [39:0] RX = {10'd40,  10'd100, 10'd120, 10'd0};
    localparam logic [39:0] RY = {10'd200, 10'd400, 10'd300, 10'd300};

    square_motion_engine #(
        .H_ACTIVE(640),
        .V_ACTIVE(480),
        .SIZE(80)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vsync(vsync),
        .enable(enable),
        .x_pos(x_pos),
        .y_pos(y_pos),
        .frame_done(frame_done),
        .busy(busy),
        .overrun(overrun),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        drop;     // deassert enable right after the tick
        logic [39:0] ex;
        logic [39:0] ey;
        logic [7:0]  ecnt;
        int          edone;    // frame_done cycle after detection, -1 none
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Raise vsync, then watch 9 cycles. k=0 is the cycle after detection.
    task automatic run_frame(input logic drop, output int done_k,
                             output int n_done, output logic busy0);
        @(negedge clk);
        vsync  = 1'b1;
        done_k = -1;
        n_done = 0;
        busy0  = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) begin
                busy0 = busy;
                vsync = 1'b0;
                if (drop) enable = 1'b0;
            end
            if (frame_done) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
        end
    endtask

    initial begin
        int   dk;
        int   nd;
        logic b0;
        int   ovr;
        logic [7:0] c0;

        tbl[0] = '{1'b1, 1'b0, {10'd50, 10'd109, 10'd128, 10'd0},
                               {10'd209, 10'd400, 10'd293, 10'd306}, 8'd1, 5};
        tbl[1] = '{1'b1, 1'b0, {10'd60, 10'd118, 10'd136, 10'd7},
                               {10'd218, 10'd392, 10'd286, 10'd312}, 8'd2, 5};
        tbl[2] = '{1'b0, 1'b0, {10'd60, 10'd118, 10'd136, 10'd7},
                               {10'd218, 10'd392, 10'd286, 10'd312}, 8'd2, -1};
        tbl[3] = '{1'b1, 1'b1, {10'd70, 10'd127, 10'd144, 10'd14},
                               {10'd227, 10'd384, 10'd279, 10'd318}, 8'd3, 5};

        reset  = 1'b1;
        vsync  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_x", x_pos, RX);
        chk("rst_y", y_pos, RY);
        chk("rst_busy", {39'd0, busy}, 40'd0);
        chk("rst_done", {39'd0, frame_done}, 40'd0);
        chk("rst_ovr", {39'd0, overrun}, 40'd0);
        chk("rst_cnt", {32'd0, frame_cnt}, 40'd0);

        for (int i = 0; i < 4; i++) begin
            enable = tbl[i].en;
            run_frame(tbl[i].drop, dk, nd, b0);
            chk($sformatf("v%0d_latency", i), 40'(dk), 40'(tbl[i].edone));
            chk($sformatf("v%0d_ndone", i), 40'(nd), tbl[i].en ? 40'd1 : 40'd0);
            chk($sformatf("v%0d_busy", i), {39'd0, b0}, {39'd0, tbl[i].en});
            chk($sformatf("v%0d_x", i), x_pos, tbl[i].ex);
            chk($sformatf("v%0d_y", i), y_pos, tbl[i].ey);
            chk($sformatf("v%0d_cnt", i), {32'd0, frame_cnt}, {32'd0, tbl[i].ecnt});
        end

        // obj1 X: 144 rising by 8 -> clamps at 560, falls to 0, rises again
        enable = 1'b1;
        for (int f = 1; f <= 123; f++) begin
            run_frame(1'b0, dk, nd, b0);
            chk($sformatf("obj1x_le_max_f%0d", f), {39'd0, x_pos[19:10] > 10'd560}, 40'd0);
            if (f == 52)  chk("obj1x_clamp560", {30'd0, x_pos[19:10]}, 40'd560);
            if (f == 53)  chk("obj1x_after560", {30'd0, x_pos[19:10]}, 40'd552);
            if (f == 121) chk("obj1x_eight",    {30'd0, x_pos[19:10]}, 40'd8);
            if (f == 122) chk("obj1x_floor0",   {30'd0, x_pos[19:10]}, 40'd0);
            if (f == 123) chk("obj1x_rebound",  {30'd0, x_pos[19:10]}, 40'd8);
        end

        // Second vsync edge two cycles after the first detection
        c0 = frame_cnt;
        nd = 0;
        ovr = 0;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);                 // k=0
        vsync = 1'b0;
        @(negedge clk);                 // k=1
        chk("ovr_k1", {39'd0, overrun}, 40'd0);
        vsync = 1'b1;
        @(negedge clk);                 // k=2
        chk("ovr_k2", {39'd0, overrun}, 40'd1);
        if (overrun) ovr++;
        vsync = 1'b0;
        for (int k = 3; k < 13; k++) begin
            @(negedge clk);
            if (frame_done) nd++;
            if (overrun) ovr++;
        end
        chk("ovr_pulses", 40'(ovr), 40'd1);
        chk("ovr_ndone", 40'(nd), 40'd1);
        chk("ovr_cnt", {32'd0, frame_cnt}, {32'd0, c0 + 8'd1});

        // Reset during the third UPDATE cycle
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);                 // k=0
        vsync = 1'b0;
        @(negedge clk);                 // k=1
        @(negedge clk);                 // k=2: UPDATE on obj2
        chk("mid_busy_pre", {39'd0, busy}, 40'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_x", x_pos, RX);
        chk("mid_rst_y", y_pos, RY);
        chk("mid_rst_busy", {39'd0, busy}, 40'd0);
        chk("mid_rst_cnt", {32'd0, frame_cnt}, 40'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (frame_done) nd++;
        end
        chk("mid_no_done", 40'(nd), 40'd0);
        chk("mid_idle_busy", {39'd0, busy}, 40'd0);

        // First frame after the aborted update starts from reset positions
        run_frame(1'b0, dk, nd, b0);
        chk("post_rst_x", x_pos, tbl[0].ex);
        chk("post_rst_y", y_pos, tbl[0].ey);

        // Counter wrap: 255 more frames makes 256 committed since reset
        for (int f = 2; f <= 256; f++) begin
            run_frame(1'b0, dk, nd, b0);
            if (f == 255) chk("cnt_255", {32'd0, frame_cnt}, 40'd255);
        end
        chk("cnt_wrap", {32'd0, frame_cnt}, 40'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/square_motion_engine.md
SQUARE_MOTION_ENGINE -- requirements
Module: square_motion_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible width in pixels.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible height in lines.
REQ-003 SHALL have parameter SIZE, default 80, square edge length in pixels.
REQ-004 SHALL have port clk, input, 1, the single clock (pixel clock).
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port vsync, input, 1, frame sync from the timing generator, synchronous to clk.
REQ-007 SHALL have port enable, input, 1, motion enable; low freezes all positions.
REQ-008 SHALL have port x_pos, output, 40, four 10-bit left-edge X values; object i in bits [10i+9:10i].
REQ-009 SHALL have port y_pos, output, 40, four 10-bit top-edge Y values; same packing.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse when new positions are committed.
REQ-011 SHALL have port busy, output, 1, high while an update is in progress.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse when a frame tick is dropped.
REQ-013 SHALL have port frame_cnt, output, 8, committed-frame counter.

Function
REQ-014 SHALL register vsync once; a frame tick is vsync=1 sampled with the previous sample 0.
REQ-015 SHALL use FSM states IDLE, UPDATE, COMMIT.
REQ-016 SHALL transition IDLE->UPDATE on a frame tick with enable=1; ticks with enable=0 are ignored silently.
REQ-017 In UPDATE, SHALL process object index 0,1,2,3 in consecutive cycles (one object per cycle), then go to COMMIT.
REQ-018 COMMIT SHALL last one cycle, copy all working positions to x_pos/y_pos atomically, pulse frame_done, increment frame_cnt (wraps 255->0), return to IDLE.
REQ-019 x_pos/y_pos SHALL change only in COMMIT; the renderer never sees a partially updated frame.
REQ-020 frame_done SHALL assert exactly 5 cycles after the cycle in which the tick is detected.
REQ-021 busy SHALL be high in UPDATE and COMMIT, low in IDLE.
REQ-022 Step sizes: X step = 7+i, Y step = 6+i for object i.
REQ-023 Per axis, increasing direction: if pos+step >= MAX then pos:=MAX and direction flips to decreasing, else pos:=pos+step; MAX = H_ACTIVE-SIZE (X) or V_ACTIVE-SIZE (Y).
REQ-024 Per axis, decreasing direction: if pos <= step then pos:=0 and direction flips to increasing, else pos:=pos-step.
REQ-025 Arithmetic SHALL be unsigned in at least 11 bits; positions never wrap and always stay within [0, MAX].
REQ-026 A frame tick while busy=1 SHALL be dropped and SHALL pulse overrun in the detection cycle; the update in progress is unaffected.
REQ-027 enable deasserting mid-update SHALL NOT abort it; the current update completes and commits.

Reset
REQ-028 On reset: state IDLE, busy=0, frame_done=0, overrun=0, frame_cnt=0, vsync sample register=0.
REQ-029 Reset positions (x,y): obj0 (0,300), obj1 (120,300), obj2 (100,400), obj3 (40,200), in working and output registers.
REQ-030 Reset directions (X,Y; 1=increasing): obj0 (0,1), obj1 (1,0), obj2 (1,1), obj3 (1,1).
REQ-031 Reset asserted mid-update SHALL restore all reset values immediately; no frame_done for the aborted update.

Verification
REQ-032 Reset, one vsync rising edge with enable=1 -> frame_done 5 cycles after detection; obj0 (0,306) with X dir flipped to increasing; obj1 (128,293); obj3 (50,209); frame_cnt=1.
REQ-033 Same first frame -> obj2 Y clamps to 400 and flips; second frame obj2 Y=392; obj0 X=7 in second frame.
REQ-034 Run obj1 X from 120 at step 8 until pos+8 >= 560 -> X=560 exactly, then decreases by 8 per frame; never exceeds 560 nor underflows below 0.
REQ-035 Second vsync edge 2 cycles after the first detection -> overrun pulse for one cycle; exactly one frame_done; frame_cnt +1 only.
REQ-036 enable=0 with 3 vsync edges -> no busy, no frame_done, outputs unchanged; enable=1 then resumes from the frozen values.
REQ-037 Assert reset during the third UPDATE cycle -> outputs return to reset values, busy=0, no frame_done; 256 committed frames -> frame_cnt wraps to 0.
